// File: rtl/mem_stage.sv
// Memory-access stage: byte/half/word loads and stores on an internal word RAM, load results returned as a tRegOp.
// Define MEM_STAGE_ERR_CNT_EN to add the saturating oErrCnt error counter output.
package mem_stage_pkg;
    localparam int unsigned cXLEN     = 32;
    localparam int unsigned cRamDepth = 1024;

    typedef struct packed {
        logic             read;
        logic             write;
        logic [cXLEN-1:0] addr;
        logic [cXLEN-1:0] data;
        logic [2:0]       opType;
        logic [4:0]       rdAddr;
    } tMemOp;

    typedef struct packed {
        logic             dv;
        logic [4:0]       addr;
        logic [cXLEN-1:0] data;
    } tRegOp;

    localparam tRegOp cRegOp = '0;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned pRamDepth = cRamDepth,
    parameter int unsigned pXLEN     = cXLEN
) (
    input  logic  clk,
    input  logic  rst,
    input  tMemOp iMemOp,
    input  logic  iFlush,
    output logic  oBusy,
    output tRegOp oRegOp,
    output logic  oErr
`ifdef MEM_STAGE_ERR_CNT_EN
    ,
    output logic [15:0] oErrCnt
`endif
);
    localparam int unsigned AW = $clog2(pRamDepth);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t state, state_next;

    logic [pXLEN-1:0] ram [pRamDepth];
    logic [pXLEN-1:0] rdata;
    logic [1:0]       ld_off;
    logic [2:0]       ld_op;
    logic [4:0]       ld_rd;

    logic          accept, illegal, misaligned, out_of_range, bad;
    logic          do_load, do_store;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   ld_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    assign idx   = iMemOp.addr[AW+1:2];
    assign oBusy = (state == LOAD_WAIT);

    always_comb begin
        accept       = (state == IDLE) && (iMemOp.read || iMemOp.write) && !iFlush;
        illegal      = (iMemOp.read && iMemOp.write)
                    || (iMemOp.read  && !(iMemOp.opType inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
                    || (iMemOp.write && !(iMemOp.opType inside {3'b000, 3'b001, 3'b010}));
        misaligned   = ((iMemOp.opType[1:0] == 2'b01) && iMemOp.addr[0])
                    || ((iMemOp.opType[1:0] == 2'b10) && (iMemOp.addr[1:0] != 2'b00));
        out_of_range = |iMemOp.addr[pXLEN-1:AW+2];
        bad          = illegal || misaligned || out_of_range;
        do_load      = accept && iMemOp.read  && !bad;
        do_store     = accept && iMemOp.write && !bad;
    end

    // Store lanes: replicate the low byte/half across the word, then let the enables pick the lane.
    always_comb begin
        be    = '0;
        wdata = iMemOp.data[31:0];
        case (iMemOp.opType[1:0])
            2'b00: begin
                be    = 4'b0001 << iMemOp.addr[1:0];
                wdata = {4{iMemOp.data[7:0]}};
            end
            2'b01: begin
                be    = iMemOp.addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{iMemOp.data[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (do_load) state_next = LOAD_WAIT;
            LOAD_WAIT: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) ram[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (do_load) rdata <= ram[idx];
    end

    always_comb begin
        ld_byte = rdata[{ld_off, 3'b000} +: 8];
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_op)
            3'b000:  ld_data = {{(pXLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(pXLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(pXLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(pXLEN-16){1'b0}}, ld_half};
            default: ld_data = rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_off <= '0;
            ld_op  <= '0;
            ld_rd  <= '0;
            oRegOp <= cRegOp;
            oErr   <= 1'b0;
        end else begin
            oErr      <= accept && bad;
            oRegOp.dv <= 1'b0;
            if (do_load) begin
                ld_off <= iMemOp.addr[1:0];
                ld_op  <= iMemOp.opType;
                ld_rd  <= iMemOp.rdAddr;
            end
            // A flush in LOAD_WAIT drops the result entirely; rd 0 completes but never signals dv.
            if (state == LOAD_WAIT && !iFlush) begin
                oRegOp.dv   <= (ld_rd != 5'd0);
                oRegOp.addr <= ld_rd;
                oRegOp.data <= ld_data;
            end
        end
    end

`ifdef MEM_STAGE_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        oErrCnt <= '0;
        else if (oErr && oErrCnt != '1) oErrCnt <= oErrCnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: stores, sign/zero-extended loads, errors, flush and reset.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    tMemOp mem_op;
    logic  flush;
    logic  busy;
    tRegOp reg_op;
    logic  err;
`ifdef MEM_STAGE_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage #(.pRamDepth(1024), .pXLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .iMemOp (mem_op),
        .iFlush (flush),
        .oBusy  (busy),
        .oRegOp (reg_op),
        .oErr   (err)
`ifdef MEM_STAGE_ERR_CNT_EN
        ,
        .oErrCnt(err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one op for a single edge, then withdraw it; returns 1 time unit after that edge.
    task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] op, input logic [4:0] rd, input logic fl);
        mem_op.read   = r;
        mem_op.write  = w;
        mem_op.addr   = a;
        mem_op.data   = d;
        mem_op.opType = op;
        mem_op.rdAddr = rd;
        flush         = fl;
        @(posedge clk);
        #1;
        mem_op.read  = 1'b0;
        mem_op.write = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [2:0] op,
                        input logic [4:0] rd, input logic [31:0] exp);
        issue(1'b1, 1'b0, a, 32'h0, op, rd, 1'b0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_dv_early"}, {31'd0, reg_op.dv}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_dv"}, {31'd0, reg_op.dv}, 32'd1);
        check({tag, "_addr"}, {27'd0, reg_op.addr}, {27'd0, rd});
        check({tag, "_data"}, reg_op.data, exp);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_err(input string tag, input logic r, input logic w, input logic [31:0] a,
                              input logic [2:0] op);
        issue(r, w, a, 32'hDEADBEEF, op, 5'd9, 1'b0);
        check({tag, "_err"}, {31'd0, err}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        mem_op = '0;
        flush  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dv", {31'd0, reg_op.dv}, 32'd0);
        check("rst_addr", {27'd0, reg_op.addr}, 32'd0);
        check("rst_data", reg_op.data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
`ifdef MEM_STAGE_ERR_CNT_EN
        check("rst_cnt", {16'd0, err_cnt}, 32'd0);
`endif
        rst = 1'b0;

        // Word store then word load
        issue(1'b0, 1'b1, 32'h10, 32'h8899AABB, 3'b010, 5'd0, 1'b0);
        check("sw_busy", {31'd0, busy}, 32'd0);
        check("sw_err", {31'd0, err}, 32'd0);
        load("lw10", 32'h10, 3'b010, 5'd5, 32'h8899AABB);
        @(posedge clk);
        #1;
        check("dv_one_cycle", {31'd0, reg_op.dv}, 32'd0);

        // Byte store into lane 3 -> word 0x7F99AABB
        issue(1'b0, 1'b1, 32'h13, 32'hAAAAAA7F, 3'b000, 5'd0, 1'b0);
        load("lb13", 32'h13, 3'b000, 5'd1, 32'h0000007F);
        load("lbu10", 32'h10, 3'b100, 5'd2, 32'h000000BB);
        load("lb11", 32'h11, 3'b000, 5'd3, 32'hFFFFFFAA);
        load("lh12", 32'h12, 3'b001, 5'd4, 32'h00007F99);
        load("lh10", 32'h10, 3'b001, 5'd6, 32'hFFFFAABB);
        load("lhu10", 32'h10, 3'b101, 5'd8, 32'h0000AABB);
        issue(1'b0, 1'b1, 32'h12, 32'h55558001, 3'b001, 5'd0, 1'b0);
        load("lh12b", 32'h12, 3'b001, 5'd10, 32'hFFFF8001);
        load("lw10b", 32'h10, 3'b010, 5'd11, 32'h8001AABB);

        // Error cases
        issue(1'b0, 1'b1, 32'h0, 32'h01020304, 3'b010, 5'd0, 1'b0);
        expect_err("lw_mis", 1'b1, 1'b0, 32'h11, 3'b010);
        @(posedge clk);
        #1;
        check("err_pulse_end", {31'd0, err}, 32'd0);
        check("err_no_dv", {31'd0, reg_op.dv}, 32'd0);
        expect_err("sw_oor", 1'b0, 1'b1, 32'h1000, 3'b010);
        expect_err("rw_both", 1'b1, 1'b1, 32'h0, 3'b010);
        @(posedge clk);
        #1;
`ifdef MEM_STAGE_ERR_CNT_EN
        check("cnt3", {16'd0, err_cnt}, 32'd3);
`endif
        expect_err("lh_mis", 1'b1, 1'b0, 32'h11, 3'b001);
        expect_err("ld_illegal", 1'b1, 1'b0, 32'h0, 3'b011);
        @(posedge clk);
        #1;
`ifdef MEM_STAGE_ERR_CNT_EN
        check("cnt5", {16'd0, err_cnt}, 32'd5);
`endif
        load("lw0_kept", 32'h0, 3'b010, 5'd12, 32'h01020304);

        // Flush while a load is outstanding
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 5'd7, 1'b0);
        check("fl_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fl_no_dv", {31'd0, reg_op.dv}, 32'd0);
        check("fl_idle", {31'd0, busy}, 32'd0);

        // Flush in IDLE drops a store
        issue(1'b0, 1'b1, 32'h24, 32'h11111111, 3'b010, 5'd0, 1'b0);
        issue(1'b0, 1'b1, 32'h24, 32'h22222222, 3'b010, 5'd0, 1'b1);
        check("fl_st_err", {31'd0, err}, 32'd0);
        load("lw24", 32'h24, 3'b010, 5'd13, 32'h11111111);

        // rd 0: load runs, no dv
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 5'd0, 1'b0);
        check("rd0_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check("rd0_no_dv", {31'd0, reg_op.dv}, 32'd0);

        // Reset in the middle of a load
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 5'd7, 1'b0);
        check("rl_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rl_busy_clr", {31'd0, busy}, 32'd0);
        check("rl_dv_clr", {31'd0, reg_op.dv}, 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rl_no_dv", {31'd0, reg_op.dv}, 32'd0);
        load("rl_ram_kept", 32'h10, 3'b010, 5'd14, 32'h8001AABB);

        // Back-to-back store then load of same word
        issue(1'b0, 1'b1, 32'h20, 32'h12345678, 3'b010, 5'd0, 1'b0);
        load("b2b", 32'h20, 3'b010, 5'd15, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
